// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between the vector sweep driver and the
// truth_table_checker response monitor.
interface truth_table_checker_if;
  logic       start;
  logic       vec_valid;
  logic [2:0] vec_in;
  logic       resp_x;
  logic       resp_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] coverage;
  logic [2:0] first_fail;
  logic       overrun;
  logic [7:0] fail_map;

  // Sweep driver side: applies vectors and DUT responses, reads results.
  modport master (
    output start, vec_valid, vec_in, resp_x, resp_y,
    input  busy, done, pass, err_count, coverage, first_fail, overrun, fail_map
  );

  // Checker side.
  modport slave (
    input  start, vec_valid, vec_in, resp_x, resp_y,
    output busy, done, pass, err_count, coverage, first_fail, overrun, fail_map
  );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: response monitor for 3-input/2-output combinational
// lab blocks. Each accepted {a,b,c} vector is allowed SETTLE_CYCLES clocks to
// settle, then resp_x/resp_y are compared against the EXP_X/EXP_Y truth tables
// (bit index = {a,b,c}). Coverage and errors accumulate until all 8 vectors
// have been compared, then done/pass are reported.
// Optional build macro TTC_FAILMAP_EN: when defined, fail_map records which
// vectors mismatched; when undefined fail_map is constant zero.
module truth_table_checker #(
  parameter logic [7:0] EXP_X         = 8'h96,
  parameter logic [7:0] EXP_Y         = 8'hE8,
  parameter int         SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_checker_if.slave bus
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt_p0;
  logic [2:0] vec_p0;
  logic       done_r;
  logic [3:0] err_r;
  logic [7:0] cov_r;
  logic [2:0] ff_r;
  logic       ovr_r;

  logic       capture;
  logic       mismatch;
  logic [7:0] cov_next;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign capture  = (state == S_ARMED) && !bus.start && bus.vec_valid;
  assign mismatch = (bus.resp_x != EXP_X[vec_p0]) || (bus.resp_y != EXP_Y[vec_p0]);
  assign cov_next = cov_r | (8'h01 << vec_p0);

  // Stage p0: hold the accepted vector while the DUT settles.
  always_ff @(posedge clk) begin
    if (capture) vec_p0 <= bus.vec_in;
  end

  // Control FSM: start always wins and clears results; compare updates results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt_p0 <= '0;
      done_r <= 1'b0;
      err_r  <= '0;
      cov_r  <= '0;
      ff_r   <= '0;
      ovr_r  <= 1'b0;
    end else if (bus.start) begin
      state  <= S_ARMED;
      done_r <= 1'b0;
      err_r  <= '0;
      cov_r  <= '0;
      ff_r   <= '0;
      ovr_r  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
        end
        S_ARMED: begin
          if (bus.vec_valid) begin
            cnt_p0 <= SETTLE_LD;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.vec_valid) ovr_r <= 1'b1;
          if (cnt_p0 <= 4'd1) state <= S_COMPARE;
          else cnt_p0 <= cnt_p0 - 4'd1;
        end
        S_COMPARE: begin
          if (bus.vec_valid) ovr_r <= 1'b1;
          cov_r <= cov_next;
          if (mismatch) begin
            err_r <= sat_inc(err_r);
            if (err_r == 4'd0) ff_r <= vec_p0;
          end
          if (cov_next == 8'hFF) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_ARMED;
          end
        end
        S_DONE: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TTC_FAILMAP_EN
  logic [7:0] fm_r;

  // Per-vector mismatch bitmap, cleared together with the other results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fm_r <= '0;
    else if (bus.start) fm_r <= '0;
    else if ((state == S_COMPARE) && mismatch) fm_r[vec_p0] <= 1'b1;
  end

  assign bus.fail_map = fm_r;
`else
  assign bus.fail_map = 8'h00;
`endif

  assign bus.busy       = (state == S_ARMED) || (state == S_SETTLE) || (state == S_COMPARE);
  assign bus.done       = done_r;
  assign bus.pass       = done_r && (err_r == 4'd0);
  assign bus.err_count  = err_r;
  assign bus.coverage   = cov_r;
  assign bus.first_fail = ff_r;
  assign bus.overrun    = ovr_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: table-driven sweeps plus
// hand-written sequences for repeats, latency, overrun, abort and reset.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  truth_table_checker_if bus ();
  truth_table_checker_if bus2 ();

  truth_table_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  truth_table_checker #(.SETTLE_CYCLES(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic       x;
    logic       y;
    logic [7:0] cov;
  } rec_t;

  rec_t tbl[8];

`ifdef TTC_FAILMAP_EN
  localparam bit FM = 1'b1;
`else
  localparam bit FM = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Apply one vector with its response, hold for 10 cycles total.
  task automatic apply(input logic [2:0] v, input logic x, input logic y);
    @(negedge clk);
    bus.vec_valid = 1'b1;
    bus.vec_in    = v;
    bus.resp_x    = x;
    bus.resp_y    = y;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int stuck_err;

    tbl[0] = '{3'd0, 1'b0, 1'b0, 8'h01};
    tbl[1] = '{3'd1, 1'b1, 1'b0, 8'h03};
    tbl[2] = '{3'd2, 1'b1, 1'b0, 8'h07};
    tbl[3] = '{3'd3, 1'b0, 1'b1, 8'h0F};
    tbl[4] = '{3'd4, 1'b1, 1'b0, 8'h1F};
    tbl[5] = '{3'd5, 1'b0, 1'b1, 8'h3F};
    tbl[6] = '{3'd6, 1'b0, 1'b1, 8'h7F};
    tbl[7] = '{3'd7, 1'b1, 1'b1, 8'hFF};

    bus.start = 1'b0; bus.vec_valid = 1'b0; bus.vec_in = '0; bus.resp_x = 1'b0; bus.resp_y = 1'b0;
    bus2.start = 1'b0; bus2.vec_valid = 1'b0; bus2.vec_in = '0; bus2.resp_x = 1'b0; bus2.resp_y = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_err", bus.err_count, 0);
    check("rst_cov", bus.coverage, 0);
    check("rst_ff", bus.first_fail, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_fm", bus.fail_map, 0);

    // vec_valid ignored in IDLE
    apply(3'd2, 1'b0, 1'b0);
    check("idle_cov", bus.coverage, 0);
    check("idle_ovr", bus.overrun, 0);
    check("idle_busy", bus.busy, 0);

    // Correct DUT sweep
    pulse_start();
    check("armed_busy", bus.busy, 1);
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].x, tbl[i].y);
      check($sformatf("ok_cov%0d", i), bus.coverage, tbl[i].cov);
      check($sformatf("ok_err%0d", i), bus.err_count, 0);
      check($sformatf("ok_done%0d", i), bus.done, (i == 7));
    end
    check("ok_pass", bus.pass, 1);
    check("ok_busy", bus.busy, 0);
    check("ok_ovr", bus.overrun, 0);
    check("ok_fm", bus.fail_map, 0);

    // vec_valid ignored in DONE
    apply(3'd7, 1'b0, 1'b0);
    check("done_ign_err", bus.err_count, 0);
    check("done_ign_ovr", bus.overrun, 0);
    check("done_ign_done", bus.done, 1);

    // Stuck x=0 sweep
    pulse_start();
    check("start_clr_done", bus.done, 0);
    check("start_clr_cov", bus.coverage, 0);
    stuck_err = 0;
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, 1'b0, tbl[i].y);
      stuck_err += int'(tbl[i].x);
      check($sformatf("sx_err%0d", i), bus.err_count, stuck_err);
    end
    check("sx_err", bus.err_count, 4);
    check("sx_ff", bus.first_fail, 1);
    check("sx_done", bus.done, 1);
    check("sx_pass", bus.pass, 0);
    check("sx_fm", bus.fail_map, FM ? 8'h96 : 8'h00);

    // Repeats: 0,0,0 with y inverted, then 1..7
    pulse_start();
    for (int k = 0; k < 3; k++) apply(3'd0, 1'b0, 1'b1);
    check("rep_cov", bus.coverage, 8'h01);
    check("rep_err3", bus.err_count, 3);
    for (int i = 1; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].x, tbl[i].y);
      if (i == 6) check("rep_notdone9", bus.done, 0);
    end
    check("rep_done10", bus.done, 1);
    check("rep_err", bus.err_count, 3);
    check("rep_ff", bus.first_fail, 0);
    check("rep_pass", bus.pass, 0);
    check("rep_fm", bus.fail_map, FM ? 8'h01 : 8'h00);

    // Latency with SETTLE_CYCLES=3 on dut2
    @(negedge clk); bus2.start = 1'b1;
    @(negedge clk); bus2.start = 1'b0;
    bus2.vec_valid = 1'b1; bus2.vec_in = 3'd5; bus2.resp_x = 1'b1; bus2.resp_y = 1'b1;
    @(posedge clk); #1;                       // E0
    bus2.vec_valid = 1'b0;
    repeat (3) @(posedge clk); #1;            // E0+3
    check("lat_cov_e3", bus2.coverage, 8'h00);
    bus2.resp_x = 1'b0;                       // correct value just before sample edge
    @(posedge clk); #1;                       // E0+4
    check("lat_cov_e4", bus2.coverage, 8'h20);
    check("lat_err_e4", bus2.err_count, 0);
    bus2.resp_x = 1'b1;                       // toggled after sampling edge
    repeat (3) @(posedge clk); #1;
    check("lat_err_late", bus2.err_count, 0);
    check("lat_busy", bus2.busy, 1);

    // Overrun: two consecutive vec_valid pulses
    pulse_start();
    @(negedge clk);
    bus.vec_valid = 1'b1; bus.vec_in = 3'd0; bus.resp_x = 1'b0; bus.resp_y = 1'b0;
    @(negedge clk);
    bus.vec_in = 3'd1;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("ovr_set", bus.overrun, 1);
    check("ovr_cov", bus.coverage, 8'h01);
    for (int i = 1; i < 8; i++) apply(tbl[i].v, tbl[i].x, tbl[i].y);
    check("ovr_done", bus.done, 1);
    check("ovr_sticky", bus.overrun, 1);
    check("ovr_err", bus.err_count, 0);

    // start with vec_valid in ARMED: start wins
    pulse_start();
    @(negedge clk);
    bus.start = 1'b1; bus.vec_valid = 1'b1; bus.vec_in = 3'd2; bus.resp_x = 1'b0; bus.resp_y = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.vec_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("sv_cov", bus.coverage, 0);
    check("sv_err", bus.err_count, 0);
    check("sv_busy", bus.busy, 1);

    // Abort mid-SETTLE
    @(negedge clk);
    bus.vec_valid = 1'b1; bus.vec_in = 3'd1; bus.resp_x = 1'b0; bus.resp_y = 1'b0;
    @(negedge clk);
    bus.vec_valid = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("ab_cov", bus.coverage, 0);
    check("ab_err", bus.err_count, 0);
    check("ab_busy", bus.busy, 1);
    apply(3'd3, 1'b0, 1'b1);
    check("ab_armed_cov", bus.coverage, 8'h08);
    apply(3'd1, 1'b0, 1'b0);
    check("ab_err1", bus.err_count, 1);
    check("ab_ff", bus.first_fail, 1);

    // Asynchronous reset mid-run
    @(negedge clk);
    bus.vec_valid = 1'b1; bus.vec_in = 3'd4;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_busy", bus.busy, 0);
    check("ar_cov", bus.coverage, 0);
    check("ar_err", bus.err_count, 0);
    check("ar_ff", bus.first_fail, 0);
    check("ar_ovr", bus.overrun, 0);
    check("ar_done", bus.done, 0);
    check("ar_pass", bus.pass, 0);
    check("ar_fm", bus.fail_map, 0);
    check("ar_busy2", bus2.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
